icache: RTL and testbench

ICACHE -- requirements
Module: icache

---
 rtl/icache_pkg.sv | 37 +++
 rtl/icache_if.sv | 34 +++
 rtl/icache.sv | 110 +++++++++++
 tb/tb_icache.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/icache_pkg.sv
// ============================================================================
// Module  : icache_pkg
// Purpose : Shared types for the direct-mapped instruction cache.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

package icache_pkg;

  localparam int ICACHE_IDX_W     = 4;
  localparam int ICACHE_TAG_MAX_W = 30;

  typedef struct packed {
    logic [31-ICACHE_IDX_W-2:0] tag;
    logic [ICACHE_IDX_W-1:0]    idx;
    logic [1:0]                 bytoff;
  } icachef_t;

  // Tag field is sized for the smallest index so any IDX_W fits, zero-extended.
  typedef struct packed {
    logic                        valid;
    logic [ICACHE_TAG_MAX_W-1:0] tag;
    logic [31:0]                 data;
  } icache_frame_t;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    FETCH = 1'b1
  } icache_state_t;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/icache_if.sv
// ============================================================================
// Module  : icache_if
// Purpose : Datapath-side and memory-side signals of the instruction cache.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

interface icache_if;

  logic        imemREN;
  logic [31:0] imemaddr;
  logic        flush;
  logic        ihit;
  logic [31:0] imemload;
  logic        iREN;
  logic [31:0] iaddr;
  logic        iwait;
  logic [31:0] iload;
  logic [15:0] hit_count;
  logic [15:0] miss_count;

  modport slave (
    input  imemREN, imemaddr, flush, iwait, iload,
    output ihit, imemload, iREN, iaddr, hit_count, miss_count
  );

  modport master (
    output imemREN, imemaddr, flush, iwait, iload,
    input  ihit, imemload, iREN, iaddr, hit_count, miss_count
  );

endinterface

`default_nettype wire

// File: rtl/icache.sv
// ============================================================================
// Module  : icache
// Purpose : Direct-mapped one-word-per-frame instruction cache with counters.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module icache
  import icache_pkg::*;
#(
  parameter int IDX_W = ICACHE_IDX_W
) (
  input  logic    CLK,
  input  logic    nRST,
  icache_if.slave bus
);

  localparam int NFRAMES = 2**IDX_W;

  icache_frame_t               r_frames [NFRAMES];
  icache_state_t               r_state;
  logic [31:0]                 r_miss_addr;
  logic [15:0]                 r_hit_count;
  logic [15:0]                 r_miss_count;

  icache_frame_t               w_frame;
  logic [IDX_W-1:0]            w_idx;
  logic [IDX_W-1:0]            w_fill_idx;
  logic [ICACHE_TAG_MAX_W-1:0] w_tag;
  logic [ICACHE_TAG_MAX_W-1:0] w_fill_tag;
  logic                        w_hit;
  logic                        w_miss;
  logic                        w_fill;
  logic                        w_unused;

  assign w_idx      = bus.imemaddr[IDX_W+1:2];
  assign w_tag      = ICACHE_TAG_MAX_W'(bus.imemaddr >> (IDX_W + 2));
  assign w_fill_idx = r_miss_addr[IDX_W+1:2];
  assign w_fill_tag = ICACHE_TAG_MAX_W'(r_miss_addr >> (IDX_W + 2));
  assign w_frame    = r_frames[w_idx];
  assign w_unused   = ^bus.imemaddr[1:0];

  assign w_hit  = (r_state == IDLE) && bus.imemREN && !bus.flush &&
                  w_frame.valid && (w_frame.tag == w_tag);
  assign w_miss = (r_state == IDLE) && bus.imemREN && !bus.flush && !w_hit;
  // An aborted request (imemREN dropped) never fills, even if memory answers.
  assign w_fill = (r_state == FETCH) && bus.imemREN && !bus.iwait && !bus.flush;

  assign bus.ihit       = w_hit;
  assign bus.imemload   = w_hit ? w_frame.data : 32'd0;
  assign bus.iREN       = (r_state == FETCH);
  assign bus.iaddr      = (r_state == FETCH) ? r_miss_addr : 32'd0;
  assign bus.hit_count  = r_hit_count;
  assign bus.miss_count = r_miss_count;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      for (int i = 0; i < NFRAMES; i++) begin
        r_frames[i] <= '0;
      end
    end else if (bus.flush) begin
      for (int i = 0; i < NFRAMES; i++) begin
        r_frames[i].valid <= 1'b0;
      end
    end else if (w_fill) begin
      r_frames[w_fill_idx] <= '{valid: 1'b1, tag: w_fill_tag, data: bus.iload};
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_state     <= IDLE;
      r_miss_addr <= 32'd0;
    end else if (bus.flush) begin
      r_state <= IDLE;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_miss) begin
            r_state     <= FETCH;
            r_miss_addr <= {bus.imemaddr[31:2], 2'b00};
          end
        end
        FETCH: begin
          if (!bus.imemREN || !bus.iwait) begin
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_hit_count  <= 16'd0;
      r_miss_count <= 16'd0;
    end else begin
      if (w_hit) begin
        r_hit_count <= sat_inc16(r_hit_count);
      end
      if (w_miss) begin
        r_miss_count <= sat_inc16(r_miss_count);
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_icache.sv
// ============================================================================
// Module  : tb_icache
// Purpose : Self-checking bench for icache: word-address reference model,
//           directed scenarios with literal expectations, random traffic.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_icache;

  localparam int IDX_W = 4;
  localparam int N     = 1 << IDX_W;

  logic CLK = 1'b0;
  logic nRST;

  icache_if bus();

  icache #(.IDX_W(IDX_W)) dut (
    .CLK  (CLK),
    .nRST (nRST),
    .bus  (bus)
  );

  always #5 CLK = ~CLK;

  int errors = 0;
  int checks = 0;

  // Reference model: each slot remembers the word address it holds.
  bit          m_val   [N];
  logic [31:0] m_waddr [N];
  logic [31:0] m_data  [N];
  bit          m_fetch;
  logic [31:0] m_maddr;
  int          m_hits;
  int          m_misses;

  function automatic logic [31:0] waddr(input logic [31:0] a);
    return {a[31:2], 2'b00};
  endfunction

  function automatic int slot(input logic [31:0] a);
    return int'((a >> 2) % N);
  endfunction

  function automatic bit exp_hit();
    int s;
    s = slot(bus.imemaddr);
    return !m_fetch && bus.imemREN && !bus.flush && m_val[s] &&
           (m_waddr[s] == waddr(bus.imemaddr));
  endfunction

  always @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      for (int i = 0; i < N; i++) begin
        m_val[i]   <= 1'b0;
        m_waddr[i] <= 32'd0;
        m_data[i]  <= 32'd0;
      end
      m_fetch  <= 1'b0;
      m_maddr  <= 32'd0;
      m_hits   <= 0;
      m_misses <= 0;
    end else begin
      if (exp_hit() && m_hits < 65535) m_hits <= m_hits + 1;
      if (bus.flush) begin
        for (int i = 0; i < N; i++) m_val[i] <= 1'b0;
        m_fetch <= 1'b0;
      end else if (!m_fetch) begin
        if (bus.imemREN && !exp_hit()) begin
          m_fetch <= 1'b1;
          m_maddr <= waddr(bus.imemaddr);
          if (m_misses < 65535) m_misses <= m_misses + 1;
        end
      end else if (!bus.imemREN) begin
        m_fetch <= 1'b0;
      end else if (!bus.iwait) begin
        m_val[slot(m_maddr)]   <= 1'b1;
        m_waddr[slot(m_maddr)] <= m_maddr;
        m_data[slot(m_maddr)]  <= bus.iload;
        m_fetch                <= 1'b0;
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge CLK) begin
    chk("ihit",       {31'd0, bus.ihit}, {31'd0, exp_hit()});
    chk("imemload",   bus.imemload,      exp_hit() ? m_data[slot(bus.imemaddr)] : 32'd0);
    chk("iREN",       {31'd0, bus.iREN}, {31'd0, m_fetch});
    chk("iaddr",      bus.iaddr,         m_fetch ? m_maddr : 32'd0);
    chk("hit_count",  {16'd0, bus.hit_count},  32'(m_hits));
    chk("miss_count", {16'd0, bus.miss_count}, 32'(m_misses));
  end

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic do_fetch(input logic [31:0] a, input logic [31:0] d, input int waits);
    bus.imemREN  = 1'b1;
    bus.imemaddr = a;
    bus.iwait    = 1'b1;
    step();
    repeat (waits) step();
    bus.iwait = 1'b0;
    bus.iload = d;
    step();
    bus.iwait = 1'b1;
  endtask

  initial begin
    logic [31:0] a;
    nRST         = 1'b0;
    bus.imemREN  = 1'b0;
    bus.imemaddr = 32'd0;
    bus.flush    = 1'b0;
    bus.iwait    = 1'b1;
    bus.iload    = 32'd0;
    #2;
    chk("rst_ihit",  {31'd0, bus.ihit}, 32'd0);
    chk("rst_iREN",  {31'd0, bus.iREN}, 32'd0);
    chk("rst_iaddr", bus.iaddr, 32'd0);
    chk("rst_miss",  {16'd0, bus.miss_count}, 32'd0);
    step();
    nRST = 1'b1;
    step();

    // Cold miss with three wait cycles.
    bus.imemREN  = 1'b1;
    bus.imemaddr = 32'h40;
    step();
    repeat (3) begin
      chk("cold_iREN",  {31'd0, bus.iREN}, 32'd1);
      chk("cold_iaddr", bus.iaddr, 32'h40);
      chk("cold_ihit",  {31'd0, bus.ihit}, 32'd0);
      step();
    end
    bus.iwait = 1'b0;
    bus.iload = 32'h8C010004;
    #1;
    chk("cold_iREN4", {31'd0, bus.iREN}, 32'd1);
    chk("cold_ihit4", {31'd0, bus.ihit}, 32'd0);
    step();
    bus.iwait = 1'b1;
    chk("cold_hit",   {31'd0, bus.ihit}, 32'd1);
    chk("cold_load",  bus.imemload, 32'h8C010004);
    chk("cold_miss",  {16'd0, bus.miss_count}, 32'd1);
    step();
    chk("cold_hitcnt", {16'd0, bus.hit_count}, 32'd1);

    // Conflict on index 0.
    do_fetch(32'h440, 32'h11110440, 1);
    chk("conf_hit440", {31'd0, bus.ihit}, 32'd1);
    bus.imemaddr = 32'h40;
    #1;
    chk("conf_miss40", {31'd0, bus.ihit}, 32'd0);
    do_fetch(32'h40, 32'h8C010004, 0);
    chk("conf_misscnt", {16'd0, bus.miss_count}, 32'd3);

    // Abort.
    bus.imemaddr = 32'h80;
    step();
    step();
    bus.imemREN = 1'b0;
    step();
    chk("abort_iREN", {31'd0, bus.iREN}, 32'd0);
    bus.imemREN = 1'b1;
    #1;
    chk("abort_remiss", {31'd0, bus.ihit}, 32'd0);
    do_fetch(32'h80, 32'h00000080, 0);

    // Address change during fetch.
    bus.imemaddr = 32'h100;
    step();
    bus.imemaddr = 32'h200;
    step();
    chk("chg_iaddr", bus.iaddr, 32'h100);
    bus.iwait = 1'b0;
    bus.iload = 32'h0000AAAA;
    step();
    bus.iwait    = 1'b1;
    bus.imemaddr = 32'h100;
    #1;
    chk("chg_hit100",  {31'd0, bus.ihit}, 32'd1);
    chk("chg_load100", bus.imemload, 32'h0000AAAA);
    step();
    bus.imemaddr = 32'h200;
    #1;
    chk("chg_miss200", {31'd0, bus.ihit}, 32'd0);
    bus.imemREN = 1'b0;
    step();

    // Flush on the fill-completion cycle.
    do_fetch(32'h44, 32'h00000044, 0);
    bus.imemaddr = 32'h40;
    step();
    bus.iwait = 1'b0;
    bus.flush = 1'b1;
    step();
    bus.flush = 1'b0;
    bus.iwait = 1'b1;
    #1;
    chk("flush_miss40", {31'd0, bus.ihit}, 32'd0);
    bus.imemaddr = 32'h44;
    #1;
    chk("flush_miss44", {31'd0, bus.ihit}, 32'd0);
    bus.imemREN = 1'b0;
    step();

    // Reset mid-fetch.
    do_fetch(32'h48, 32'h00000048, 0);
    bus.imemaddr = 32'h4C;
    step();
    #2;
    nRST = 1'b0;
    #1;
    chk("rst_mid_iREN",  {31'd0, bus.iREN}, 32'd0);
    chk("rst_mid_iaddr", bus.iaddr, 32'd0);
    step();
    nRST = 1'b1;
    bus.imemaddr = 32'h48;
    #1;
    chk("rst_mid_miss48", {31'd0, bus.ihit}, 32'd0);
    chk("rst_mid_hitcnt", {16'd0, bus.hit_count}, 32'd0);
    bus.imemREN = 1'b0;
    step();

    // Random traffic over a small address pool so hits and conflicts occur.
    a = 32'd0;
    for (int n = 0; n < 2000; n++) begin
      if ($urandom_range(0, 99) < 30)
        a = ($urandom_range(0, 3) << 6) | ($urandom_range(0, 15) << 2) | $urandom_range(0, 3);
      bus.imemaddr = a;
      bus.imemREN  = ($urandom_range(0, 99) < 85);
      bus.flush    = ($urandom_range(0, 99) < 3);
      bus.iwait    = $urandom_range(0, 1);
      bus.iload    = $urandom;
      if (n == 1000) begin
        nRST = 1'b0;
        #2;
        nRST = 1'b1;
      end
      step();
    end

    bus.imemREN = 1'b0;
    bus.flush   = 1'b0;
    step();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
